// File: rtl/mpd_pkg.sv
// Shared types and constants for the multi-button press classifier.
// Tick defaults assume the 100 Hz debounced sample clock.
package mpd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG,
    ST_CHORD,
    ST_WAIT_REL
  } state_e;

  localparam int DEF_MIN_TICKS    = 2;
  localparam int DEF_LONG_TICKS   = 50;
  localparam int DEF_REPEAT_TICKS = 10;

  function automatic int cnt_width(input int long_ticks);
    return $clog2(long_ticks + 1);
  endfunction

  function automatic int rcnt_width(input int repeat_ticks);
    return $clog2(repeat_ticks + 1);
  endfunction

endpackage

// File: rtl/multi_press_detector_channel.sv
// One button channel: classifies a press as short, long or auto-repeat, or
// parks in CHORD when the top level pulls it into a multi-button chord.
module press_channel
  import mpd_pkg::*;
#(
  parameter int MIN_TICKS    = DEF_MIN_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk_100Hz,
  input  logic rst,
  input  logic btn_q,
  input  logic join_chord,
  input  logic long_block,
  output logic short_press,
  output logic long_press,
  output logic repeat_press,
  output logic in_chord,
  output logic in_long
);

  localparam int CW = cnt_width(LONG_TICKS);
  localparam int RW = rcnt_width(REPEAT_TICKS);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          can_join;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rcnt_d   = rcnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    can_join = join_chord && !long_block;

    case (state_q)
      ST_IDLE: begin
        if (can_join) begin
          state_d = ST_CHORD;
          cnt_d   = '0;
        end else if (btn_q) begin
          state_d = ST_HELD;
          cnt_d   = CW'(1);
        end
      end
      ST_HELD: begin
        if (can_join) begin
          state_d = ST_CHORD;
          cnt_d   = '0;
        end else if (!btn_q) begin
          short_d = (cnt_q >= CW'(MIN_TICKS));
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CW'(LONG_TICKS - 1)) begin
          long_d  = 1'b1;
          state_d = ST_LONG;
          cnt_d   = CW'(LONG_TICKS);
          rcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LONG: begin
        if (!btn_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          rcnt_d  = '0;
        end else if (REPEAT_EN) begin
          if (rcnt_q == RW'(REPEAT_TICKS - 1)) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
      end
      // WAIT_REL is reserved and behaves exactly like CHORD.
      ST_CHORD, ST_WAIT_REL: begin
        if (!btn_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rcnt_d  = '0;
      end
    endcase
  end

  // NOTE: reset is sampled on the clock edge (synchronous), so it sits inside
  // the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rcnt_q   <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rcnt_q   <= rcnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign repeat_press = repeat_q;
  assign in_chord     = (state_q == ST_CHORD) || (state_q == ST_WAIT_REL);
  assign in_long      = (state_q == ST_LONG);

endmodule

// File: rtl/multi_press_detector.sv
// N-channel press classifier: input register, per-channel FSMs, and the
// chord detect/accumulate logic that reports multi-button presses.
module multi_press_detector
  import mpd_pkg::*;
#(
  parameter int N            = 2,
  parameter int MIN_TICKS    = DEF_MIN_TICKS,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic         clk_100Hz,
  input  logic         rst,
  input  logic [N-1:0] btn,
  output logic [N-1:0] short_press,
  output logic [N-1:0] long_press,
  output logic [N-1:0] repeat_press,
  output logic         chord,
  output logic [N-1:0] chord_mask
);

  logic [N-1:0] btn_q, btn_d;
  logic [N-1:0] chord_acc_q, chord_acc_d;
  logic [N-1:0] chord_mask_q, chord_mask_d;
  logic         chord_q, chord_d;

  logic [N-1:0] in_chord;
  logic [N-1:0] in_long;
  logic [N-1:0] join_chord;
  logic [N-1:0] joined;
  logic         any_chord;
  logic         multi;
  logic         long_veto;
  logic         chord_done;

  always_comb begin
    btn_d      = btn;
    any_chord  = |in_chord;
    multi      = (btn_q & (btn_q - N'(1))) != '0;
    // A held long press vetoes starting a chord, but never an ongoing one.
    long_veto  = (|(btn_q & in_long)) && !any_chord;
    join_chord = (any_chord || multi) ? (btn_q & ~in_long) : '0;
    joined     = long_veto ? '0 : (join_chord & ~in_chord);
    chord_done = any_chord && !(|(btn_q & ~in_long));

    chord_d      = chord_done;
    chord_mask_d = chord_done ? chord_acc_q : '0;
    chord_acc_d  = chord_done ? '0 : (chord_acc_q | joined);
  end

  // NOTE: btn_q is a plain sample register with no reset, so a button held
  // through reset is seen as pressed on the first edge after release.
  always_ff @(posedge clk_100Hz) begin
    btn_q <= btn_d;
  end

  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      chord_q      <= 1'b0;
      chord_mask_q <= '0;
      chord_acc_q  <= '0;
    end else begin
      chord_q      <= chord_d;
      chord_mask_q <= chord_mask_d;
      chord_acc_q  <= chord_acc_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    press_channel #(
      .MIN_TICKS   (MIN_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .REPEAT_EN   (REPEAT_EN)
    ) u_ch (
      .clk_100Hz   (clk_100Hz),
      .rst         (rst),
      .btn_q       (btn_q[i]),
      .join_chord  (join_chord[i]),
      .long_block  (long_veto),
      .short_press (short_press[i]),
      .long_press  (long_press[i]),
      .repeat_press(repeat_press[i]),
      .in_chord    (in_chord[i]),
      .in_long     (in_long[i])
    );
  end

  assign chord      = chord_q;
  assign chord_mask = chord_mask_q;

endmodule

// File: tb/tb_multi_press_detector.sv
// Randomized scoreboard bench: a hold-length reference model predicts every
// output pulse; a negedge monitor compares whatever the two DUTs present.
module tb_multi_press_detector;

  typedef struct {
    int         len[8];
    bit         lg[8];
    bit         cd[8];
    logic [7:0] acc;
  } model_t;

  typedef struct {
    int          cyc;
    logic [39:0] ev;
  } exp_t;

  logic       clk_100Hz = 1'b0;
  logic       rst       = 1'b1;
  logic [2:0] btn       = '0;

  logic [1:0] sp1, lp1, rp1, cm1;
  logic       ch1;
  logic [2:0] sp2, lp2, rp2, cm2;
  logic       ch2;

  int         cyc      = 0;
  bit         rst_edge = 1'b1;
  logic [7:0] bq_m     = '0;
  model_t     m1, m2;
  exp_t       q1[$];
  exp_t       q2[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk_100Hz = ~clk_100Hz;

  multi_press_detector #(
    .N(2), .MIN_TICKS(2), .LONG_TICKS(50), .REPEAT_TICKS(10), .REPEAT_EN(1'b1)
  ) dut (
    .clk_100Hz(clk_100Hz), .rst(rst), .btn(btn[1:0]),
    .short_press(sp1), .long_press(lp1), .repeat_press(rp1),
    .chord(ch1), .chord_mask(cm1)
  );

  multi_press_detector #(
    .N(3), .MIN_TICKS(3), .LONG_TICKS(12), .REPEAT_TICKS(4), .REPEAT_EN(1'b0)
  ) dut_nr (
    .clk_100Hz(clk_100Hz), .rst(rst), .btn(btn),
    .short_press(sp2), .long_press(lp2), .repeat_press(rp2),
    .chord(ch2), .chord_mask(cm2)
  );

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    else
      n_pass++;
  endtask

  function automatic void model_reset(inout model_t m);
    for (int i = 0; i < 8; i++) begin
      m.len[i] = 0;
      m.lg[i]  = 1'b0;
      m.cd[i]  = 1'b0;
    end
    m.acc = '0;
  endfunction

  // Press classification from hold lengths: len counts sampled-pressed edges.
  function automatic void model_step(inout model_t m, input logic [7:0] p, input int n,
                                     input int mn, input int lt, input int rt,
                                     input bit ren, output logic [39:0] ev);
    bit         any_c = 1'b0;
    bit         lblk  = 1'b0;
    bit         still = 1'b0;
    bit         jn;
    int         np    = 0;
    logic [7:0] sp = '0, lp = '0, rp = '0, cm = '0;
    bit         ch = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (m.cd[i]) any_c = 1'b1;
      if (p[i]) np++;
      if (p[i] && m.lg[i]) lblk = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      jn = p[i] && !m.lg[i] && !m.cd[i] && (any_c || (np >= 2 && !lblk));
      if (m.cd[i]) begin
        if (!p[i]) m.cd[i] = 1'b0;
      end else if (jn) begin
        m.cd[i]  = 1'b1;
        m.acc[i] = 1'b1;
        m.len[i] = 0;
      end else if (m.lg[i]) begin
        if (p[i]) begin
          m.len[i]++;
          if (ren && ((m.len[i] - lt) % rt == 0)) rp[i] = 1'b1;
        end else begin
          m.lg[i]  = 1'b0;
          m.len[i] = 0;
        end
      end else if (m.len[i] > 0) begin
        if (p[i]) begin
          m.len[i]++;
          if (m.len[i] == lt) begin
            lp[i]   = 1'b1;
            m.lg[i] = 1'b1;
          end
        end else begin
          if (m.len[i] >= mn) sp[i] = 1'b1;
          m.len[i] = 0;
        end
      end else if (p[i]) begin
        m.len[i] = 1;
      end
    end
    for (int i = 0; i < n; i++) if (m.cd[i]) still = 1'b1;
    if (any_c && !still) begin
      ch    = 1'b1;
      cm    = m.acc;
      m.acc = '0;
    end
    ev = {7'b0, ch, cm, rp, lp, sp};
  endfunction

  // Reference model: runs on each active edge, pushes the expected pulses.
  initial forever begin
    logic [39:0] ev;
    @(posedge clk_100Hz);
    cyc++;
    rst_edge = rst;
    if (rst) begin
      model_reset(m1);
      model_reset(m2);
    end else begin
      model_step(m1, bq_m & 8'h03, 2, 2, 50, 10, 1'b1, ev);
      if (ev != '0) q1.push_back('{cyc, ev});
      model_step(m2, bq_m & 8'h07, 3, 3, 12, 4, 1'b0, ev);
      if (ev != '0) q2.push_back('{cyc, ev});
    end
    bq_m = {5'b0, btn};
  end

  // Monitor: pops on every presented pulse or predicted event.
  initial forever begin
    logic [39:0] a1, a2;
    exp_t        e;
    @(negedge clk_100Hz);
    a1 = {7'b0, ch1, 6'b0, cm1, 6'b0, rp1, 6'b0, lp1, 6'b0, sp1};
    a2 = {7'b0, ch2, 5'b0, cm2, 5'b0, rp2, 5'b0, lp2, 5'b0, sp2};
    if (rst_edge) begin
      check("reset_zero_dut", a1, '0);
      check("reset_zero_dut_nr", a2, '0);
    end else begin
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        e = q1.pop_front();
        check("event_dut", a1, e.ev);
      end else if (a1 != '0) begin
        check("spurious_dut", a1, '0);
      end
      if (q2.size() > 0 && q2[0].cyc == cyc) begin
        e = q2.pop_front();
        check("event_dut_nr", a2, e.ev);
      end else if (a2 != '0) begin
        check("spurious_dut_nr", a2, '0);
      end
    end
  end

  task automatic set_btn(input logic [2:0] v, input int n);
    btn = v;
    repeat (n) @(posedge clk_100Hz);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk_100Hz);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk_100Hz);
    #1;
    rst = 1'b0;
    set_btn(3'b000, 4);

    set_btn(3'b001, 5);  set_btn(3'b000, 10);   // short press
    set_btn(3'b010, 1);  set_btn(3'b000, 10);   // glitch
    set_btn(3'b010, 80); set_btn(3'b000, 10);   // long + repeats
    set_btn(3'b011, 30); set_btn(3'b010, 3);    // chord, staggered release
    set_btn(3'b000, 10);
    set_btn(3'b010, 30); pulse_rst();           // reset mid-press
    set_btn(3'b010, 60); set_btn(3'b000, 10);
    set_btn(3'b001, 60); set_btn(3'b011, 25);   // long ch0 + independent ch1
    set_btn(3'b000, 10);
    set_btn(3'b101, 2);  set_btn(3'b111, 4);    // short chord, late joiner
    set_btn(3'b000, 10);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) pulse_rst();
      set_btn(3'($urandom_range(0, 7)), $urandom_range(1, 70));
    end

    set_btn(3'b000, 20);
    check("queue_dut_drained", 40'(q1.size()), '0);
    check("queue_dut_nr_drained", 40'(q2.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_press_detector.md
Name: multi_press_detector

Overview:
- Parametrised successor of the two-button long/short press detector used by the alarm-clock setting logic.
- Classifies presses on N debounced button lines, each sampled on the 100 Hz tick clock, into four kinds: short press, long press, auto-repeat while held, and multi-button chord.
- Sits between the debouncers and the time/alarm set FSM; every output is a one-cycle pulse qualified per channel.

Parameters:
- N, 2, number of button channels (2..8).
- MIN_TICKS, 2, minimum held cycles for a valid press; shorter presses are discarded as glitches.
- LONG_TICKS, 50, held cycles at which a press becomes long (0.5 s at 100 Hz); must exceed MIN_TICKS.
- REPEAT_TICKS, 10, cycles between repeat pulses once long.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 gives a single long pulse only.

Ports:
- clk_100Hz  in  1  system tick clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- btn  in  N  debounced button levels, 1 = pressed.
- short_press  out  N  1-cycle pulse: short press completed on that channel.
- long_press  out  N  1-cycle pulse: channel reached LONG_TICKS while held.
- repeat_press  out  N  1-cycle pulse every REPEAT_TICKS after long_press while held.
- chord  out  1  1-cycle pulse: chord completed.
- chord_mask  out  N  channels in the chord; valid only while chord=1, otherwise 0.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high, named rst; the clock is named clk_100Hz.
- On rst=1 at an edge: all outputs are 0, all channel FSMs go to IDLE, counters are 0, and the accumulated chord mask is cleared. rst overrides all inputs, including mid-press. After reset is released, a button already held is treated as a press starting at the first non-reset cycle.
- Inputs are registered once (btn_q); all decisions use btn_q. Latency is 1 cycle from a btn edge to the FSM seeing it.
- Per-channel FSM states: IDLE, HELD, LONG, CHORD, WAIT_REL.
  - IDLE: on btn_q=1, go to HELD with cnt=1.
  - HELD: cnt increments each cycle, saturating at LONG_TICKS.
    - On btn_q=0 with cnt>=MIN_TICKS: short_press pulses on the same edge the release is seen; go to IDLE.
    - On btn_q=0 with cnt<MIN_TICKS: go to IDLE silently.
    - When cnt reaches LONG_TICKS: long_press pulses; go to LONG with rcnt=0.
  - LONG: rcnt increments. If REPEAT_EN and rcnt==REPEAT_TICKS-1, repeat_press pulses and rcnt resets to 0. On release, go to IDLE with no further pulse.
  - CHORD: wait for this channel's release, then go to IDLE. No short, long or repeat pulses.
  - WAIT_REL: reserved for a channel stuck held after a chord; treated as CHORD.
- Chord rule:
  - If, on one edge, at least 2 channels are pressed (btn_q=1) and none of them is in LONG, every pressed channel in HELD or IDLE moves to CHORD, and its bit is ORed into chord_acc.
  - Further channels pressed while any channel is in CHORD also join.
  - When all channels in CHORD have released, chord pulses for 1 cycle with chord_mask=chord_acc, then chord_acc clears.
  - A chord of fewer than MIN_TICKS cycles is still reported.
- Simultaneous events:
  - A channel already in LONG never joins a chord; it keeps repeating.
  - A new press on another channel while one channel is in LONG is handled as an independent press.
  - Output pulses on different channels in the same cycle are legal.
- Counter widths: $clog2(LONG_TICKS+1) and $clog2(REPEAT_TICKS+1). No wrap is possible because cnt saturates.
- No output is ever asserted for two consecutive cycles from the same event.

Decomposition:
- Package mpd_pkg holds:
  - the state enum (IDLE, HELD, LONG, CHORD, WAIT_REL);
  - the counter-width functions;
  - the default tick constants (MIN, LONG, REPEAT for 100 Hz).
- Sub-module press_channel: one per-channel FSM with counters. It takes btn_q, a join_chord input and a long_block input, and produces short, long and repeat pulses plus an in_chord flag.
- The top level instantiates N press_channel blocks via generate, and holds the input register, chord detect/accumulate logic and the chord pulse.

Test Plan:
- Default parameters, btn[0] held 5 cycles then released -> exactly one short_press[0] pulse, 1 cycle after the release edge reaches btn_q; no other outputs.
- btn[1] held 1 cycle -> no pulse on any output (glitch rejection, below MIN_TICKS=2).
- btn[1] held 80 cycles -> long_press[1] at held cycle 50; repeat_press[1] at cycles 60 and 70 (and 80 only if still held); nothing on release.
- Same as the previous scenario but with REPEAT_EN=0 -> a single long_press[1] and no repeat pulses.
- btn=2'b11 asserted on the same edge, held 30 cycles, released 3 cycles apart -> one chord pulse after the last release with chord_mask=2'b11; no short_press.
- rst=1 for 1 cycle during a held press at cycle 30 -> all outputs 0. The press restarts from cnt=1, so long_press comes 50 cycles after reset is released.
